execute_mc: RTL and testbench

EXECUTE_MC -- requirements
Module: execute_mc

---
 rtl/exec_pkg.sv | 23 ++
 rtl/execute_alu.sv | 36 +++
 rtl/execute_mc.sv | 133 +++++++++++++
 tb/tb_execute_mc.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/exec_pkg.sv
// Shared definitions for the execute unit: op codes, sequencer state encoding
// and the default datapath width.
package exec_pkg;

    localparam int WIDTH_DEF = 16;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_SLL = 4'd5;
    localparam logic [3:0] OP_SRL = 4'd6;
    localparam logic [3:0] OP_SRA = 4'd7;
    localparam logic [3:0] OP_MUL = 4'd8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/execute_alu.sv
// Single-cycle combinational operations. Anything outside ADD..SRA (including
// MUL, which the sequencer handles itself) is flagged as an error with a zero result.
module execute_alu
    import exec_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       op,
    output logic [WIDTH-1:0] out,
    output logic             err
);

    localparam int SW = $clog2(WIDTH);

    logic [SW-1:0] shamt;
    assign shamt = b[SW-1:0];

    always_comb begin
        out = '0;
        err = 1'b0;
        case (op)
            OP_ADD:  out = a + b;
            OP_SUB:  out = a - b;
            OP_AND:  out = a & b;
            OP_OR:   out = a | b;
            OP_XOR:  out = a ^ b;
            OP_SLL:  out = a << shamt;
            OP_SRL:  out = a >> shamt;
            OP_SRA:  out = $signed(a) >>> shamt;
            default: err = 1'b1;
        endcase
    end

endmodule

// File: rtl/execute_mc.sv
// Execute unit: valid/ready sequencer, optional shift-add multiplier and result register.
// Define EXECUTE_MC_MUL_EN to build the multiplier; otherwise op 8 is reported illegal.
//
// state  | meaning
// S_IDLE | waiting for an operation, in_ready=1
// S_BUSY | multiplier iterating one bit per cycle
// S_DONE | result/err held with out_valid=1 until consumed
module execute_mc
    import exec_pkg::*;
#(
    parameter int WIDTH      = WIDTH_DEF,
    parameter int MUL_CYCLES = WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] data1,
    input  logic [WIDTH-1:0] data2,
    input  logic [WIDTH-1:0] immediate,
    input  logic [3:0]       alu_op,
    input  logic             rt_sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             err
);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] b_sel;
    logic [WIDTH-1:0] alu_out;
    logic             alu_err;
    logic             accept;
    logic             is_mul;
    logic             busy_done;

    assign b_sel  = rt_sel ? data2 : immediate;
    assign accept = in_valid && in_ready;

    execute_alu #(.WIDTH(WIDTH)) u_alu (
        .a   (data1),
        .b   (b_sel),
        .op  (alu_op),
        .out (alu_out),
        .err (alu_err)
    );

`ifdef EXECUTE_MC_MUL_EN
    localparam int CW = $clog2(MUL_CYCLES + 1);

    logic [WIDTH-1:0] mul_a, mul_b, acc, step;
    logic [CW-1:0]    cnt;

    assign is_mul    = (alu_op == OP_MUL);
    assign step      = mul_a[0] ? mul_b : '0;
    assign busy_done = (cnt == CW'(MUL_CYCLES - 1));

    // Multiplicand shifts left, multiplier shifts right; product kept modulo 2^WIDTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mul_a <= '0;
            mul_b <= '0;
            acc   <= '0;
            cnt   <= '0;
        end else if (accept && is_mul) begin
            mul_a <= data1;
            mul_b <= b_sel;
            acc   <= '0;
            cnt   <= '0;
        end else if (state == S_BUSY) begin
            mul_a <= mul_a >> 1;
            mul_b <= mul_b << 1;
            acc   <= acc + step;
            cnt   <= cnt + 1'b1;
        end
    end
`else
    logic unused_cfg;
    assign unused_cfg = ^MUL_CYCLES;
    assign is_mul     = 1'b0;
    assign busy_done  = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (in_valid) state_nxt = is_mul ? S_BUSY : S_DONE;
            S_BUSY: if (busy_done) state_nxt = S_DONE;
            S_DONE: begin
                if (out_ready) begin
                    if (in_valid) state_nxt = is_mul ? S_BUSY : S_DONE;
                    else          state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            S_IDLE: in_ready = rst_n;
            S_DONE: begin
                out_valid = 1'b1;
                in_ready  = rst_n && out_ready;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result <= '0;
            err    <= 1'b0;
        end else if (accept && !is_mul) begin
            result <= alu_out;
            err    <= alu_err;
        end
`ifdef EXECUTE_MC_MUL_EN
        else if (state == S_BUSY && busy_done) begin
            result <= acc + step;
            err    <= 1'b0;
        end
`endif
    end

endmodule

// File: tb/tb_execute_mc.sv
// Directed bench for execute_mc (WIDTH=16); multiplier cases follow EXECUTE_MC_MUL_EN.
module tb_execute_mc;
    import exec_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] data1, data2, immediate;
    logic [3:0]  alu_op;
    logic        rt_sel;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] result;
    logic        err;

    int checks = 0;
    int errors = 0;

    execute_mc #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data1     (data1),
        .data2     (data2),
        .immediate (immediate),
        .alu_op    (alu_op),
        .rt_sel    (rt_sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    // Called just after a negedge; presents one op and checks the result one cycle later.
    task automatic op1(input string tag, input logic [3:0] op, input logic [15:0] d1,
                       input logic [15:0] d2, input logic [15:0] imm, input logic rt,
                       input logic [15:0] er, input logic ee);
        alu_op = op; data1 = d1; data2 = d2; immediate = imm; rt_sel = rt;
        in_valid = 1'b1;
        #1 chk({tag, "_rdy"}, in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        data1 = 16'hDEAD; data2 = 16'hBEEF; immediate = 16'hCAFE;
        chk({tag, "_vld"}, out_valid, 1);
        chk({tag, "_res"}, result, er);
        chk({tag, "_err"}, err, ee);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        data1 = '0; data2 = '0; immediate = '0; alu_op = '0; rt_sel = 1'b0;
        #2;
        chk("rst_rdy", in_ready, 0);
        chk("rst_vld", out_valid, 0);
        chk("rst_res", result, 0);
        chk("rst_err", err, 0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;

        // first accept on the first edge after release
        op1("add",  OP_ADD, 16'h1234, 16'h0F0F, 16'h5555, 1'b1, 16'h2143, 1'b0);
        op1("sub",  OP_SUB, 16'h0005, 16'h9999, 16'h0007, 1'b0, 16'hFFFE, 1'b0);
        op1("sra",  OP_SRA, 16'h8000, 16'h0000, 16'h0004, 1'b0, 16'hF800, 1'b0);
        op1("and",  OP_AND, 16'hF0F0, 16'h3C3C, 16'h0000, 1'b1, 16'h3030, 1'b0);
        op1("or",   OP_OR,  16'hF0F0, 16'h0000, 16'h0F01, 1'b0, 16'hFFF1, 1'b0);
        op1("xor",  OP_XOR, 16'hFFFF, 16'h1234, 16'h0000, 1'b1, 16'hEDCB, 1'b0);
        op1("sll15",OP_SLL, 16'h0001, 16'h000F, 16'h0000, 1'b1, 16'h8000, 1'b0);
        op1("srl15",OP_SRL, 16'h8000, 16'h0000, 16'h000F, 1'b0, 16'h0001, 1'b0);
        op1("sllm", OP_SLL, 16'h0011, 16'h0013, 16'h0000, 1'b1, 16'h0088, 1'b0);
        op1("addw", OP_ADD, 16'hFFFF, 16'h0000, 16'h0002, 1'b0, 16'h0001, 1'b0);
        op1("ill12",4'd12,  16'h1111, 16'h2222, 16'h3333, 1'b1, 16'h0000, 1'b1);
        op1("add2", OP_ADD, 16'h0001, 16'h0001, 16'h0000, 1'b1, 16'h0002, 1'b0);
        op1("ill15",4'd15,  16'h1111, 16'h2222, 16'h3333, 1'b0, 16'h0000, 1'b1);

`ifdef EXECUTE_MC_MUL_EN
        begin
            logic [15:0] ma [3] = '{16'h00FF, 16'h1234, 16'hFFFF};
            logic [15:0] mb [3] = '{16'h0101, 16'h0010, 16'hFFFF};
            logic [15:0] mp [3] = '{16'hFFFF, 16'h2340, 16'h0001};
            for (int k = 0; k < 3; k++) begin
                @(negedge clk);
                alu_op = OP_MUL; data1 = ma[k]; data2 = mb[k]; rt_sel = 1'b1; in_valid = 1'b1;
                @(negedge clk);
                in_valid = 1'b0; data1 = 16'h7777; data2 = 16'h3333;
                for (int c = 0; c < 16; c++) begin
                    chk($sformatf("mul%0d_busy_rdy%0d", k, c), in_ready, 0);
                    chk($sformatf("mul%0d_busy_vld%0d", k, c), out_valid, 0);
                    @(negedge clk);
                end
                chk($sformatf("mul%0d_vld", k), out_valid, 1);
                chk($sformatf("mul%0d_res", k), result, mp[k]);
                chk($sformatf("mul%0d_err", k), err, 0);
            end
        end
`else
        op1("mul_ill", OP_MUL, 16'h00FF, 16'h0101, 16'h0000, 1'b1, 16'h0000, 1'b1);
`endif

        // hold result while consumer stalls; pending op must not be taken
        @(negedge clk);
        out_ready = 1'b0;
        op1("hold", OP_ADD, 16'h0003, 16'h0004, 16'h0000, 1'b1, 16'h0007, 1'b0);
        alu_op = OP_XOR; data1 = 16'h00FF; data2 = 16'h0F0F; rt_sel = 1'b1; in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk($sformatf("hold_vld%0d", c), out_valid, 1);
            chk($sformatf("hold_res%0d", c), result, 16'h0007);
            chk($sformatf("hold_err%0d", c), err, 0);
            chk($sformatf("hold_rdy%0d", c), in_ready, 0);
        end
        out_ready = 1'b1;
        #1 chk("b2b_rdy", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        chk("b2b_vld", out_valid, 1);
        chk("b2b_res", result, 16'h0FF0);
        @(negedge clk);
        chk("b2b_idle", out_valid, 0);

`ifdef EXECUTE_MC_MUL_EN
        alu_op = OP_MUL; data1 = 16'h00FF; data2 = 16'h0101; rt_sel = 1'b1; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (6) @(negedge clk);
`else
        out_ready = 1'b0;
        alu_op = OP_ADD; data1 = 16'h0100; data2 = 16'h0001; rt_sel = 1'b1; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk("pre_rst_vld", out_valid, 1);
        @(negedge clk);
`endif
        rst_n = 1'b0;
        #1;
        chk("mrst_vld", out_valid, 0);
        chk("mrst_rdy", in_ready, 0);
        chk("mrst_res", result, 0);
        chk("mrst_err", err, 0);
        @(negedge clk);
        rst_n = 1'b1; out_ready = 1'b1;
        begin
            int seen = 0;
            repeat (20) begin
                @(negedge clk);
                if (out_valid) seen++;
            end
            chk("mrst_no_stale", seen, 0);
        end
        chk("mrst_idle_rdy", in_ready, 1);
        op1("post_rst", OP_SUB, 16'h0010, 16'h0001, 16'h0000, 1'b1, 16'h000F, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
